// File: rtl/fifo_push_arbiter_pkg.sv
// Package for the FIFO push arbiter.
// Holds the shared data type, the arbiter sizing constants, the index and
// counter types, the FSM state enum and two small index helpers.
// Ports: none (package only).
package fifo_push_arbiter_pkg;

  // Data path width shared with the FIFO.
  localparam int W_DATA = 8;
  typedef logic [W_DATA-1:0] data_t;

  // Arbiter sizing.
  localparam int N_REQ     = 4;   // 2..16 requesters
  localparam int MAX_BURST = 4;   // 1..256 words per grant
  localparam int IDX_W     = $clog2(N_REQ);
  localparam int CNT_W     = $clog2(MAX_BURST) + 1;

  typedef logic [IDX_W-1:0] req_idx_t;
  typedef logic [CNT_W-1:0] burst_cnt_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // One-hot vector with bit i set.
  function automatic logic [N_REQ-1:0] idx_onehot(req_idx_t i);
    logic [N_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // (i + 1) mod N_REQ, valid for non-power-of-two N_REQ as well.
  function automatic req_idx_t idx_next(req_idx_t i);
    if (i == req_idx_t'(N_REQ - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Interface bundling the requester side and the FIFO write side of the
// push arbiter.
// Signals:
//   req / req_data  per-requester valid and packed data (index i at [i*W_DATA +: W_DATA])
//   ack             per-requester accept, combinational
//   gnt / owner     registered one-hot grant and index of the holder
//   busy / state    arbiter in BURST / raw FSM state for observation
//   fifo_full       FIFO full flag in, fifo_push / fifo_data out
// Handshake: req[i] is a valid; a word transfers in a cycle where
// req[i] & ack[i] is 1 at the clock edge. ack[i] is only ever 1 together with
// fifo_push, so every acked word is exactly one FIFO write. Once req[i] is 1
// the requester keeps req_data[i] stable until ack[i]; it may drop req[i] at
// any time, which takes no word.
// Modports: master = requesters + FIFO model side, slave = the arbiter.
interface fifo_push_arbiter_if;
  import fifo_push_arbiter_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*W_DATA-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        gnt;
  req_idx_t                owner;
  logic                    busy;
  arb_state_t              state;
  logic                    fifo_full;
  logic                    fifo_push;
  data_t                   fifo_data;

  modport master (
    output req, req_data, fifo_full,
    input  ack, gnt, owner, busy, state, fifo_push, fifo_data
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, gnt, owner, busy, state, fifo_push, fifo_data
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
// Searches req starting at rr_ptr and wrapping modulo N_REQ; the first set
// bit wins.
// Ports:
//   req     in   N_REQ      request vector
//   rr_ptr  in   req_idx_t  index with highest priority this cycle
//   any     out  1          at least one request is set
//   winner  out  req_idx_t  index of the selected request (0 when none)
module fifo_push_arbiter_rr_pick
  import fifo_push_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         rr_ptr,
  output logic             any,
  output req_idx_t         winner
);

  req_idx_t cand;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = req_idx_t'((int'(rr_ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// A grant lasts until MAX_BURST words are written or the owner drops its
// request; then one idle cycle passes and the next requester after the
// previous owner wins. A full FIFO stalls the burst without releasing it.
// Ports:
//   clk  in  write-domain clock, posedge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of fifo_push_arbiter_if (requests, grant, FIFO write)
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fifo_push_arbiter_if.slave bus
);

  localparam burst_cnt_t LAST_CNT = burst_cnt_t'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  req_idx_t         owner_q, owner_d;
  req_idx_t         rr_ptr_q, rr_ptr_d;
  burst_cnt_t       burst_cnt_q, burst_cnt_d;

  logic     pick_any;
  req_idx_t pick_winner;
  logic     in_burst;
  logic     owner_req;
  logic     push;
  data_t    owner_data;

  fifo_push_arbiter_rr_pick u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Select the owner's word with constant slices.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == req_idx_t'(i)) begin
        owner_data = bus.req_data[i*W_DATA +: W_DATA];
      end
    end
  end

  assign in_burst  = (state_q == ARB_BURST);
  assign owner_req = bus.req[owner_q];
  assign push      = in_burst & owner_req & ~bus.fifo_full;

  assign bus.fifo_push = push;
  assign bus.fifo_data = push ? owner_data : '0;
  assign bus.ack       = push ? idx_onehot(owner_q) : '0;
  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = in_burst;
  assign bus.state     = state_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_BURST;
          gnt_d       = idx_onehot(pick_winner);
          owner_d     = pick_winner;
          burst_cnt_d = '0;
        end
      end
      ARB_BURST: begin
        // A withdrawn request releases without taking a word; the last word
        // of a full burst is still written in the releasing cycle.
        if (!owner_req || (push && (burst_cnt_q == LAST_CNT))) begin
          state_d     = ARB_IDLE;
          gnt_d       = '0;
          rr_ptr_d    = idx_next(owner_q);
          burst_cnt_d = '0;
        end else if (push) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_fifo_push_arbiter;
  import fifo_push_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   push_cnt = 0;

  data_t rd [N_REQ];
  logic [W_DATA-1:0] exp_q[$];

  fifo_push_arbiter_if bus ();

  fifo_push_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and FIFO write counter.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.fifo_push === 1'b1) push_cnt <= push_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver tasks.
  task automatic drive_data();
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*W_DATA +: W_DATA] = rd[i];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '1;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) rd[i] = data_t'(8'hA0 + i);
    drive_data();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks += 3;
      if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt actual=%b required=0000", bus.gnt); end
      if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL reset_push actual=%b required=0", bus.fifo_push); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_release_gnt actual=%b required=0000", bus.gnt); end
    @(negedge clk);
    #1;
    checks += 2;
    if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_grant actual=%b required=0001", bus.gnt); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_first_busy actual=%b required=1", bus.busy); end
    bus.req = '0;
  endtask

  task automatic test_burst_limit();
    logic  last_ack;
    logic  exp_push;
    data_t e;
    apply_reset();
    exp_q = {};
    for (int k = 0; k < 8; k++) exp_q.push_back(data_t'(8'h10 + k));
    rd[0] = 8'h10;
    drive_data();
    bus.req = 4'b0001;
    last_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (last_ack) rd[0] = rd[0] + 8'd1;
        drive_data();
      end
      #1;
      exp_push = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
      checks++;
      if (bus.fifo_push !== exp_push) begin failures++; $display("FAIL burst_push c=%0d actual=%b required=%b", c, bus.fifo_push, exp_push); end
      if (bus.fifo_push === 1'b1) begin
        checks += 2;
        if (bus.ack !== 4'b0001) begin failures++; $display("FAIL burst_ack c=%0d actual=%b required=0001", c, bus.ack); end
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL burst_data c=%0d actual=%h required=none", c, bus.fifo_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.fifo_data !== e) begin failures++; $display("FAIL burst_data c=%0d actual=%h required=%h", c, bus.fifo_data, e); end
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL burst_bubble_gnt actual=%b required=0000", bus.gnt); end
      end
      last_ack = bus.ack[0];
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL burst_leftover actual=%0d required=0", exp_q.size()); end
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] last_ack;
    logic [N_REQ-1:0] g_q[$];
    int               words[$];
    logic             prev_busy;
    logic [N_REQ-1:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int i = 0; i < N_REQ; i++) rd[i] = data_t'(i * 16);
    drive_data();
    bus.req = '1;
    last_ack = '0;
    prev_busy = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c > 0) begin
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) if (last_ack[i]) rd[i] = rd[i] + 8'd1;
        drive_data();
      end
      #1;
      if ((bus.busy === 1'b1) && !prev_busy) begin
        g_q.push_back(bus.gnt);
        words.push_back(0);
      end
      if ((bus.fifo_push === 1'b1) && (words.size() > 0)) words[words.size()-1] += 1;
      prev_busy = (bus.busy === 1'b1);
      last_ack = bus.ack;
    end
    checks++;
    if (g_q.size() != 5) begin failures++; $display("FAIL rr_grant_count actual=%0d required=5", g_q.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < g_q.size()) begin
        checks += 2;
        if (g_q[k] !== exp_g[k]) begin failures++; $display("FAIL rr_grant k=%0d actual=%b required=%b", k, g_q[k], exp_g[k]); end
        if (words[k] != MAX_BURST) begin failures++; $display("FAIL rr_words k=%0d actual=%0d required=%0d", k, words[k], MAX_BURST); end
      end
    end
    bus.req = '0;
  endtask

  task automatic test_full_stall();
    logic  last_ack;
    data_t ed;
    apply_reset();
    rd[1] = 8'h20;
    drive_data();
    bus.req = 4'b0010;
    last_ack = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (last_ack) rd[1] = rd[1] + 8'd1;
        bus.fifo_full = (c >= 3) && (c <= 7);
        drive_data();
      end
      #1;
      if ((c == 1) || (c == 2) || (c == 8) || (c == 9)) begin
        ed = (c < 3) ? data_t'(8'h20 + c - 1) : data_t'(8'h20 + c - 6);
        checks += 2;
        if (bus.fifo_push !== 1'b1) begin failures++; $display("FAIL stall_push c=%0d actual=%b required=1", c, bus.fifo_push); end
        if (bus.fifo_data !== ed) begin failures++; $display("FAIL stall_data c=%0d actual=%h required=%h", c, bus.fifo_data, ed); end
      end
      if ((c >= 3) && (c <= 7)) begin
        checks += 3;
        if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL stall_full_push c=%0d actual=%b required=0", c, bus.fifo_push); end
        if (bus.ack !== 4'b0000) begin failures++; $display("FAIL stall_full_ack c=%0d actual=%b required=0000", c, bus.ack); end
        if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL stall_full_gnt c=%0d actual=%b required=0010", c, bus.gnt); end
      end
      if (c == 10) begin
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL stall_release_gnt actual=%b required=0000", bus.gnt); end
      end
      last_ack = bus.ack[1];
    end
    bus.req = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic test_withdraw();
    apply_reset();
    rd[2] = 8'h30;
    rd[3] = 8'h40;
    rd[1] = 8'h50;
    drive_data();
    bus.req = 4'b0100;
    #1;
    @(negedge clk);
    #1;
    checks += 3;
    if (bus.fifo_push !== 1'b1) begin failures++; $display("FAIL wd_push actual=%b required=1", bus.fifo_push); end
    if (bus.ack !== 4'b0100) begin failures++; $display("FAIL wd_ack actual=%b required=0100", bus.ack); end
    if (bus.fifo_data !== 8'h30) begin failures++; $display("FAIL wd_data actual=%h required=30", bus.fifo_data); end
    @(negedge clk);
    bus.req = 4'b1010;
    #1;
    checks += 3;
    if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL wd_drop_push actual=%b required=0", bus.fifo_push); end
    if (bus.ack !== 4'b0000) begin failures++; $display("FAIL wd_drop_ack actual=%b required=0000", bus.ack); end
    if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL wd_drop_gnt actual=%b required=0100", bus.gnt); end
    @(negedge clk);
    #1;
    checks += 2;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL wd_bubble_gnt actual=%b required=0000", bus.gnt); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL wd_bubble_busy actual=%b required=0", bus.busy); end
    @(negedge clk);
    #1;
    checks += 2;
    if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL wd_next_gnt actual=%b required=1000", bus.gnt); end
    if (bus.owner !== 2'd3) begin failures++; $display("FAIL wd_next_owner actual=%0d required=3", bus.owner); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.ack !== 4'b1000) begin failures++; $display("FAIL wd_owner3_ack actual=%b required=1000", bus.ack); end
    for (int c = 6; c < 10; c++) @(negedge clk);
    #1;
    checks++;
    if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL wd_pending_gnt actual=%b required=0010", bus.gnt); end
    bus.req = '0;
  endtask

  task automatic test_async_reset();
    int cnt_before;
    apply_reset();
    rd[0] = 8'h55;
    drive_data();
    bus.req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks += 2;
    if (bus.fifo_push !== 1'b1) begin failures++; $display("FAIL ar_push_before actual=%b required=1", bus.fifo_push); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL ar_busy_before actual=%b required=1", bus.busy); end
    cnt_before = push_cnt;
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL ar_gnt actual=%b required=0000", bus.gnt); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL ar_busy actual=%b required=0", bus.busy); end
    if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL ar_push actual=%b required=0", bus.fifo_push); end
    @(posedge clk);
    #1;
    checks++;
    if (push_cnt != cnt_before) begin failures++; $display("FAIL ar_word_count actual=%0d required=%0d", push_cnt, cnt_before); end
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
  endtask

  task automatic test_random();
    logic             m_busy;
    int               m_owner, m_taken, m_rr, idx;
    logic             found;
    logic [N_REQ-1:0] last_ack, e_gnt, e_ack;
    logic             e_push;
    data_t            e_data;
    apply_reset();
    m_busy = 1'b0; m_owner = 0; m_taken = 0; m_rr = 0;
    last_ack = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req[i] && !last_ack[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
        end else begin
          bus.req[i] = ($urandom_range(0, 9) < 6);
          rd[i] = data_t'($urandom);
        end
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      drive_data();
      #1;
      e_gnt  = m_busy ? (N_REQ'(1) << m_owner) : '0;
      e_push = m_busy && bus.req[req_idx_t'(m_owner)] && !bus.fifo_full;
      e_data = e_push ? rd[m_owner] : '0;
      e_ack  = e_push ? e_gnt : '0;
      checks += 5;
      if (bus.gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d actual=%b required=%b", cyc, bus.gnt, e_gnt); end
      if (bus.busy !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d actual=%b required=%b", cyc, bus.busy, m_busy); end
      if (bus.fifo_push !== e_push) begin failures++; $display("FAIL rnd_push cyc=%0d actual=%b required=%b", cyc, bus.fifo_push, e_push); end
      if (bus.fifo_data !== e_data) begin failures++; $display("FAIL rnd_data cyc=%0d actual=%h required=%h", cyc, bus.fifo_data, e_data); end
      if (bus.ack !== e_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d actual=%b required=%b", cyc, bus.ack, e_ack); end
      if (m_busy) begin
        checks++;
        if (bus.owner !== req_idx_t'(m_owner)) begin failures++; $display("FAIL rnd_owner cyc=%0d actual=%0d required=%0d", cyc, bus.owner, m_owner); end
      end
      last_ack = bus.ack;
      // Model advance for the coming edge.
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_rr + k) % N_REQ;
          if (!found && bus.req[req_idx_t'(idx)]) begin found = 1'b1; m_owner = idx; end
        end
        if (found) begin m_busy = 1'b1; m_taken = 0; end
      end else if (!bus.req[req_idx_t'(m_owner)] || (e_push && (m_taken + 1 == MAX_BURST))) begin
        m_busy = 1'b0;
        m_rr = (m_owner + 1) % N_REQ;
      end else if (e_push) begin
        m_taken++;
      end
    end
    bus.req = '0;
    bus.fifo_full = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) rd[i] = '0;
    drive_data();
    test_reset();
    test_burst_limit();
    test_round_robin();
    test_full_stall();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
